// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: performs one WIDE_BIT add/subtract as NUM_SEG
// back-to-back OPERAND_BIT-wide passes through a single ripple adder,
// LSB segment first, with the inter-segment carry held in a register.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE (and is held 0 while reset is
// asserted); out_valid is 1 only in DONE. Once out_valid is 1, out_sum,
// out_cout and out_ovf stay constant until the edge where out_ready is
// seen, or until clear/reset.

// Ripple-carry adder for one segment. The carry walks bit by bit so the
// chain length is OPERAND_BIT, never WIDE_BIT.
module wide_add_seg_adder #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic carry;

    // Bit-serial ripple: sum bit and generate/propagate carry per position
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module wide_add_sequencer #(
    parameter int OPERAND_BIT = 10,
    parameter int NUM_SEG     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OPERAND_BIT*NUM_SEG-1:0] in_a,
    input  logic [OPERAND_BIT*NUM_SEG-1:0] in_b,
    input  logic                           in_cin,
    input  logic                           in_sub,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OPERAND_BIT*NUM_SEG-1:0] out_sum,
    output logic                           out_cout,
    output logic                           out_ovf
);

    localparam int WIDE_BIT = OPERAND_BIT * NUM_SEG;
    // A single-segment build still needs a 1-bit counter
    localparam int CNT_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [WIDE_BIT-1:0]    a_reg;
    logic [WIDE_BIT-1:0]    b_reg;
    logic [WIDE_BIT-1:0]    sum_reg;
    logic                   carry_reg;
    logic                   a_msb;
    logic                   b_eff_msb;
    logic [CNT_W-1:0]       seg_cnt;

    logic [OPERAND_BIT-1:0] seg_a;
    logic [OPERAND_BIT-1:0] seg_b;
    logic [OPERAND_BIT-1:0] seg_sum;
    logic                   seg_cout;
    logic [WIDE_BIT-1:0]    sum_next;
    logic [WIDE_BIT-1:0]    b_eff;
    logic                   accept;

    // Subtraction is A + ~B + 1: invert B at capture, force carry-in to 1
    always_comb begin
        b_eff  = in_sub ? ~in_b : in_b;
        accept = in_valid && in_ready;
    end

    // The low segment of each operand register feeds the shared adder
    always_comb begin
        seg_a = a_reg[OPERAND_BIT-1:0];
        seg_b = b_reg[OPERAND_BIT-1:0];
    end

    wide_add_seg_adder #(
        .WIDTH (OPERAND_BIT)
    ) u_seg_adder (
        .a    (seg_a),
        .b    (seg_b),
        .cin  (carry_reg),
        .sum  (seg_sum),
        .cout (seg_cout)
    );

    // New segment enters at the top; after NUM_SEG passes the LSB segment
    // has walked down to bit 0 and the register holds the full result.
    generate
        if (NUM_SEG == 1) begin : g_single_seg
            always_comb sum_next = seg_sum;
        end else begin : g_multi_seg
            always_comb sum_next = {seg_sum, sum_reg[WIDE_BIT-1:OPERAND_BIT]};
        end
    endgenerate

    // Sequencer FSM: capture in IDLE, one segment per cycle in RUN, hold in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            a_msb     <= 1'b0;
            b_eff_msb <= 1'b0;
            seg_cnt   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            // Abort wins over any acceptance in the same cycle
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            a_msb     <= 1'b0;
            b_eff_msb <= 1'b0;
            seg_cnt   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    if (accept) begin
                        a_reg     <= in_a;
                        b_reg     <= b_eff;
                        carry_reg <= in_sub ? 1'b1 : in_cin;
                        a_msb     <= in_a[WIDE_BIT-1];
                        b_eff_msb <= b_eff[WIDE_BIT-1];
                        seg_cnt   <= '0;
                        in_ready  <= 1'b0;
                        state     <= ST_RUN;
                    end else begin
                        // Also raises in_ready on the first edge after reset
                        in_ready  <= 1'b1;
                    end
                end

                ST_RUN: begin
                    in_ready  <= 1'b0;
                    a_reg     <= a_reg >> OPERAND_BIT;
                    b_reg     <= b_reg >> OPERAND_BIT;
                    sum_reg   <= sum_next;
                    carry_reg <= seg_cout;
                    seg_cnt   <= seg_cnt + CNT_W'(1);
                    if (seg_cnt == LAST_SEG) begin
                        // seg_sum is the MSB segment here, so its top bit is
                        // the sign of the final result
                        out_valid <= 1'b1;
                        out_cout  <= seg_cout;
                        out_ovf   <= (a_msb == b_eff_msb) &&
                                     (seg_sum[OPERAND_BIT-1] != a_msb);
                        state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // The sum register is the result; it only becomes meaningful with out_valid
    always_comb out_sum = sum_reg;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer at OPERAND_BIT=10, NUM_SEG=4.
// Expected results come from a plain-arithmetic reference model.
module tb_wide_add_sequencer;

    localparam int OB = 10;
    localparam int NS = 4;
    localparam int W  = OB * NS;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_checks;
    int n_errors;

    wide_add_sequencer #(
        .OPERAND_BIT (OB),
        .NUM_SEG     (NS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: modular sum, unsigned carry/no-borrow, signed range check
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input logic sub,
                                      output logic [W-1:0] s, output logic c,
                                      output logic o);
        longint sa, sb, sr, max_s, min_s;
        logic [W:0] wide;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        max_s = (longint'(1) << (W - 1)) - 1;
        min_s = -(longint'(1) << (W - 1));
        if (sub) begin
            s  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            s    = wide[W-1:0];
            c    = wide[W];
            sr   = sa + sb + longint'(cin);
        end
        o = (sr > max_s) || (sr < min_s);
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = {8'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    // Accept one operation, check latency and result, optionally consume it
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input bit consume);
        logic [W-1:0] es;
        logic ec, eo;
        int guard, lat;
        ref_model(a, b, cin, sub, es, ec, eo);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s accept_timeout in_ready=%b required 1", tag, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (lat !== NS) begin
            n_errors++;
            $display("FAIL %s latency got=%0d required=%0d", tag, lat, NS);
        end
        n_checks++;
        if (out_sum !== es) begin
            n_errors++;
            $display("FAIL %s sum got=%h required=%h", tag, out_sum, es);
        end
        n_checks++;
        if (out_cout !== ec || out_ovf !== eo) begin
            n_errors++;
            $display("FAIL %s flags got cout=%b ovf=%b required cout=%b ovf=%b",
                     tag, out_cout, out_ovf, ec, eo);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s in_ready_in_done got=%b required 0", tag, in_ready);
        end
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL %s valid_drop got=%b required 0", tag, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        #2;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== '0 ||
            out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values got rdy=%b vld=%b sum=%h c=%b o=%b required all 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold_ready got=%b required 0", in_ready);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready got=%b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        run_op("seg_carry",     40'h00000003FF, 40'h0000000001, 1'b0, 1'b0, 1'b1);
        run_op("full_ripple",   40'hFFFFFFFFFF, 40'h0000000000, 1'b1, 1'b0, 1'b1);
        run_op("sub_borrow",    40'd5,          40'd7,          1'b1, 1'b1, 1'b1);
        run_op("sub_no_borrow", 40'd7,          40'd5,          1'b0, 1'b1, 1'b1);
        run_op("ovf_add",       40'h7FFFFFFFFF, 40'h0000000001, 1'b0, 1'b0, 1'b1);
        run_op("ovf_sub",       40'h8000000000, 40'h0000000001, 1'b0, 1'b1, 1'b1);
        run_op("neg_add_ovf",   40'h8000000001, 40'h8000000001, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op("random", rand_wide(), rand_wide(), 1'($urandom), 1'($urandom), 1'b1);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] es;
        logic ec, eo;
        int bad;
        ref_model(40'h123456789A, 40'h0FEDCBA987, 1'b1, 1'b0, es, ec, eo);
        run_op("bp_first", 40'h123456789A, 40'h0FEDCBA987, 1'b1, 1'b0, 1'b0);
        bad = 0;
        in_a = 40'h00000003FF; in_b = 40'h0000000001; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_sum !== es || out_cout !== ec ||
                out_ovf !== eo || in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL backpressure_hold bad_cycles=%0d required 0 (sum=%h exp=%h rdy=%b)",
                     bad, out_sum, es, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_release got vld=%b rdy=%b required vld=0 rdy=1",
                     out_valid, in_ready);
        end
        run_op("bp_next", 40'h00000003FF, 40'h0000000001, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort_reset();
        int guard, spurious;
        in_a = 40'h123456789A; in_b = 40'h0111111111; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== '0 || in_ready !== 1'b0 || out_cout !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_reset got vld=%b sum=%h rdy=%b c=%b required 0 0 0 0",
                     out_valid, out_sum, in_ready, out_cout);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_errors++;
            $display("FAIL abort_reset_spurious got=%0d required 0", spurious);
        end
        run_op("after_reset", 40'h00000003FF, 40'h0000000001, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear();
        int spurious;
        run_op("clr_first", 40'h8000000001, 40'h8000000001, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 ||
            out_ovf !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_done got vld=%b sum=%h c=%b o=%b rdy=%b required 0 0 0 0 1",
                     out_valid, out_sum, out_cout, out_ovf, in_ready);
        end
        // clear and a valid request on the same edge: nothing is accepted
        in_a = 40'h0000000005; in_b = 40'h0000000006; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_priority got rdy=%b required 1", in_ready);
        end
        spurious = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_errors++;
            $display("FAIL clear_priority_spurious got=%0d required 0", spurious);
        end
        run_op("after_clear", 40'h00000003FF, 40'h0000000001, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] exp_q[$];
        logic [W+1:0] exp_v;
        logic [W-1:0] es;
        logic ec, eo;
        int n_sent, n_got, cyc, last_out;
        bit acc;
        n_sent = 0; n_got = 0; cyc = 0; last_out = -1;
        out_ready = 1'b1;
        in_a = rand_wide(); in_b = rand_wide();
        in_cin = 1'($urandom); in_sub = 1'($urandom);
        in_valid = 1'b1;
        while (n_got < 10 && cyc < 300) begin
            if (out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL b2b_unexpected_result sum=%h required none", out_sum);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({out_ovf, out_cout, out_sum} !== exp_v) begin
                        n_errors++;
                        $display("FAIL b2b_result got o=%b c=%b sum=%h required o=%b c=%b sum=%h",
                                 out_ovf, out_cout, out_sum, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
                    end
                end
                if (last_out >= 0) begin
                    n_checks++;
                    if (cyc - last_out != NS + 2) begin
                        n_errors++;
                        $display("FAIL b2b_interval got=%0d required=%0d", cyc - last_out, NS + 2);
                    end
                end
                last_out = cyc;
                n_got++;
            end
            acc = (in_valid === 1'b1) && (in_ready === 1'b1);
            if (acc) begin
                ref_model(in_a, in_b, in_cin, in_sub, es, ec, eo);
                exp_q.push_back({eo, ec, es});
                n_sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (n_sent == 10) in_valid = 1'b0;
                in_a = rand_wide(); in_b = rand_wide();
                in_cin = 1'($urandom); in_sub = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_got != 10) begin
            n_errors++;
            $display("FAIL b2b_count got=%0d required=10", n_got);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_abort_reset();
        test_clear();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
